// File: rtl/seq_signed_divider.sv
// Iterative signed divider: restoring division on operand magnitudes, one quotient bit per
// clock, followed by a single sign-fix cycle. Fixed latency for every operand pair.
module seq_signed_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int unsigned MW   = WIDTH + 1;
  localparam int unsigned CntW = $clog2(WIDTH + 2);

  localparam logic [CntW-1:0]  CntInit = CntW'(WIDTH + 1);
  localparam logic [CntW-1:0]  CntOne  = CntW'(1);
  localparam logic [WIDTH-1:0] MinNeg  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]    rem_q, rem_d;
  logic [MW-1:0]    dvd_q, dvd_d;
  logic [MW-1:0]    dsr_q, dsr_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_b_q, sign_b_d;
  logic             dz_q, dz_d;
  logic             ovf_q, ovf_d;

  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_by_zero_q, div_by_zero_d;
  logic             overflow_q, overflow_d;
  logic             done_q, done_d;

  // Magnitudes are one bit wider so that |-2^(WIDTH-1)| is representable.
  logic [MW-1:0] a_sext, b_sext, a_mag, b_mag;
  assign a_sext = {dividend[WIDTH-1], dividend};
  assign b_sext = {divisor[WIDTH-1], divisor};
  assign a_mag  = dividend[WIDTH-1] ? -a_sext : a_sext;
  assign b_mag  = divisor[WIDTH-1]  ? -b_sext : b_sext;

  // Shared shift/trial-subtract datapath; the extra top bit of trial is its sign.
  logic [MW:0] shifted, trial;
  logic        trial_ok;
  assign shifted  = {rem_q, dvd_q[MW-1]};
  assign trial    = shifted - {1'b0, dsr_q};
  assign trial_ok = ~trial[MW];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    dvd_d         = dvd_q;
    dsr_d         = dsr_q;
    quo_d         = quo_q;
    dividend_d    = dividend_q;
    sign_a_d      = sign_a_q;
    sign_b_d      = sign_b_q;
    dz_d          = dz_q;
    ovf_d         = ovf_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    overflow_d    = overflow_q;
    done_d        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StCalc;
          cnt_d      = CntInit;
          rem_d      = '0;
          quo_d      = '0;
          dvd_d      = a_mag;
          dsr_d      = b_mag;
          dividend_d = dividend;
          sign_a_d   = dividend[WIDTH-1];
          sign_b_d   = divisor[WIDTH-1];
          dz_d       = (divisor == '0);
          ovf_d      = (dividend == MinNeg) && (divisor == '1);
        end
      end

      StCalc: begin
        rem_d = trial_ok ? trial[MW-1:0] : shifted[MW-1:0];
        quo_d = {quo_q[WIDTH-2:0], trial_ok};
        dvd_d = {dvd_q[MW-2:0], 1'b0};
        cnt_d = cnt_q - CntOne;
        if (cnt_q == CntOne) begin
          state_d = StFix;
        end
      end

      StFix: begin
        state_d       = StIdle;
        done_d        = 1'b1;
        div_by_zero_d = dz_q;
        overflow_d    = ovf_q;
        if (dz_q) begin
          quotient_d  = '1;
          remainder_d = dividend_q;
        end else begin
          // Magnitudes here never exceed 2^(WIDTH-1), so the low WIDTH bits suffice.
          quotient_d  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
          remainder_d = sign_a_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dsr_q         <= '0;
      quo_q         <= '0;
      dividend_q    <= '0;
      sign_a_q      <= 1'b0;
      sign_b_q      <= 1'b0;
      dz_q          <= 1'b0;
      ovf_q         <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
      overflow_q    <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      dvd_q         <= dvd_d;
      dsr_q         <= dsr_d;
      quo_q         <= quo_d;
      dividend_q    <= dividend_d;
      sign_a_q      <= sign_a_d;
      sign_b_q      <= sign_b_d;
      dz_q          <= dz_d;
      ovf_q         <= ovf_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
      overflow_q    <= overflow_d;
      done_q        <= done_d;
    end
  end

  assign busy        = (state_q != StIdle);
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_signed_divider.sv
// Directed bench for seq_signed_divider (WIDTH=8): vector table plus handshake/reset sequences.
module tb_seq_signed_divider;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero, overflow;
  logic [7:0] quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  seq_signed_divider #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    logic       ov;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Counts edges after the accepting edge (starting from 'from') until done, bounded.
  task automatic wait_done(input string name, input int from, output int lat);
    logic busy_ok;
    busy_ok = 1'b1;
    lat = from;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!done && lat < 10) busy_ok &= busy;
    end while (!done && lat < 40);
    chk({name, " latency"}, lat, 10);
    chk({name, " busy during op"}, {31'd0, busy_ok}, 1);
    chk({name, " busy low at done"}, {31'd0, busy}, 0);
  endtask

  task automatic accept(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int    lat;
    string nm;
    nm = $sformatf("vec%0d %0d/%0d", idx, $signed(v.a), $signed(v.b));
    accept(v.a, v.b);
    chk({nm, " busy after accept"}, {31'd0, busy}, 1);
    wait_done(nm, 0, lat);
    chk({nm, " quotient"}, {24'd0, quotient}, {24'd0, v.q});
    chk({nm, " remainder"}, {24'd0, remainder}, {24'd0, v.r});
    chk({nm, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, v.dz});
    chk({nm, " overflow"}, {31'd0, overflow}, {31'd0, v.ov});
    @(posedge clk);
    #1;
    chk({nm, " done single pulse"}, {31'd0, done}, 0);
    chk({nm, " quotient held"}, {24'd0, quotient}, {24'd0, v.q});
  endtask

  initial begin
    int lat;
    int ndone;

    vecs[0]  = '{a: 8'd100,  b: 8'd7,    q: 8'h0E, r: 8'h02, dz: 1'b0, ov: 1'b0};
    vecs[1]  = '{a: 8'h9C,   b: 8'd7,    q: 8'hF2, r: 8'hFE, dz: 1'b0, ov: 1'b0};
    vecs[2]  = '{a: 8'd100,  b: 8'hF9,   q: 8'hF2, r: 8'h02, dz: 1'b0, ov: 1'b0};
    vecs[3]  = '{a: 8'h9C,   b: 8'hF9,   q: 8'h0E, r: 8'hFE, dz: 1'b0, ov: 1'b0};
    vecs[4]  = '{a: 8'h80,   b: 8'hFF,   q: 8'h80, r: 8'h00, dz: 1'b0, ov: 1'b1};
    vecs[5]  = '{a: 8'h80,   b: 8'h01,   q: 8'h80, r: 8'h00, dz: 1'b0, ov: 1'b0};
    vecs[6]  = '{a: 8'h80,   b: 8'h03,   q: 8'hD6, r: 8'hFE, dz: 1'b0, ov: 1'b0};
    vecs[7]  = '{a: 8'd37,   b: 8'h00,   q: 8'hFF, r: 8'h25, dz: 1'b1, ov: 1'b0};
    vecs[8]  = '{a: 8'd127,  b: 8'h80,   q: 8'h00, r: 8'h7F, dz: 1'b0, ov: 1'b0};
    vecs[9]  = '{a: 8'h80,   b: 8'h80,   q: 8'h01, r: 8'h00, dz: 1'b0, ov: 1'b0};
    vecs[10] = '{a: 8'h00,   b: 8'd5,    q: 8'h00, r: 8'h00, dz: 1'b0, ov: 1'b0};
    vecs[11] = '{a: 8'hFF,   b: 8'd2,    q: 8'h00, r: 8'hFF, dz: 1'b0, ov: 1'b0};
    vecs[12] = '{a: 8'hEC,   b: 8'h00,   q: 8'hFF, r: 8'hEC, dz: 1'b1, ov: 1'b0};
    vecs[13] = '{a: 8'd127,  b: 8'd1,    q: 8'h7F, r: 8'h00, dz: 1'b0, ov: 1'b0};

    rst_n = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset busy", {31'd0, busy}, 0);
    chk("reset done", {31'd0, done}, 0);
    chk("reset quotient", {24'd0, quotient}, 0);
    chk("reset remainder", {24'd0, remainder}, 0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 0);
    chk("reset overflow", {31'd0, overflow}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // start re-pulsed at edge k+4 with other operands must be ignored
    accept(8'd100, 8'd7);
    repeat (3) @(posedge clk);
    @(negedge clk);
    start = 1'b1;
    dividend = 8'd20;
    divisor = 8'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("repulse", 4, lat);
    chk("repulse quotient", {24'd0, quotient}, 32'h0E);
    chk("repulse remainder", {24'd0, remainder}, 32'h02);

    // start in the done cycle is accepted with no idle gap
    accept(8'd100, 8'd7);
    wait_done("b2b first", 0, lat);
    chk("b2b first quotient", {24'd0, quotient}, 32'h0E);
    start = 1'b1;
    dividend = 8'd50;
    divisor = 8'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b done dropped", {31'd0, done}, 0);
    chk("b2b busy after accept", {31'd0, busy}, 1);
    wait_done("b2b second", 0, lat);
    chk("b2b quotient", {24'd0, quotient}, 32'h0A);
    chk("b2b remainder", {24'd0, remainder}, 32'h00);

    // Async reset between edges k+4 and k+5 discards the operation
    accept(8'd100, 8'd7);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid reset busy", {31'd0, busy}, 0);
    chk("mid reset done", {31'd0, done}, 0);
    chk("mid reset quotient", {24'd0, quotient}, 0);
    chk("mid reset remainder", {24'd0, remainder}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ndone = 0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("no done after reset", ndone, 0);
    run_vec('{a: 8'd9, b: 8'd2, q: 8'd4, r: 8'd1, dz: 1'b0, ov: 1'b0}, 99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_signed_divider.md
Name: seq_signed_divider

Overview:
- Iterative signed integer divider: the inverse operation of the team's combinational signed Booth multiplier.
- Produces quotient and remainder of two WIDTH-bit two's-complement operands.
- Computes one magnitude bit per clock using a shared subtract datapath, then applies a sign-fix cycle.
- Used as a multi-cycle arithmetic unit behind a start/done handshake, e.g. so that multiply-then-divide round trips can be checked.

Parameters:
WIDTH, 8, operand and result width in bits (two's complement), minimum 2

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
dividend  input  WIDTH  signed dividend, sampled on accepting edge
divisor  input  WIDTH  signed divisor, sampled on accepting edge
busy  output  1  high from acceptance until the cycle done is asserted
done  output  1  one-cycle pulse; results valid from this cycle
quotient  output  WIDTH  signed quotient, truncated toward zero
remainder  output  WIDTH  signed remainder, sign follows dividend (0 allowed)
div_by_zero  output  1  divisor was 0 for the latched operation
overflow  output  1  operation was most-negative / -1

Behaviour:
- Clock and reset: one clock, clk. Reset is rst_n, asynchronous and active-low.
- Reset (async, any time, including mid-operation):
  - state=IDLE.
  - busy, done, quotient, remainder, div_by_zero and overflow all 0.
  - In-flight operation discarded; no done is produced for it.
- FSM states: IDLE, CALC, FIX.
- IDLE:
  - start=1 at an edge latches the operands and goes to CALC; busy=1 after that edge.
  - Latched at the same edge: magnitudes |dividend| and |divisor| as WIDTH+1-bit unsigned values (so |-2^(WIDTH-1)| is representable), both sign bits, and the dz/ovf flags.
  - Iteration counter loaded with WIDTH+1.
- CALC (exactly WIDTH+1 cycles): restoring unsigned division, one bit per cycle.
  - Shift the partial remainder left, bringing in the next dividend-magnitude MSB.
  - Trial-subtract the divisor magnitude.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set 0.
  - Decrement the counter; when it reaches 0, go to FIX.
- FIX (1 cycle):
  - quotient = neg(Qmag) if the operand signs differ, else Qmag, truncated to WIDTH.
  - remainder = neg(Rmag) if the dividend is negative, else Rmag.
  - Outputs registered; done=1 and busy=0 for the following cycle; state returns to IDLE.
- Latency: done is high in the cycle after edge k+WIDTH+2, where k is the accepting edge (10 edges for WIDTH=8). Latency is fixed for all operands, including the special cases below.
- Divide by zero (divisor==0):
  - div_by_zero=1, quotient = all ones, remainder = dividend, overflow=0.
  - Same latency; the CALC result is overridden in FIX.
- Overflow (dividend = -2^(WIDTH-1), divisor = -1):
  - quotient = -2^(WIDTH-1) (wrapped), remainder=0, overflow=1.
- Flags are valid together with done.
- Result holding:
  - quotient, remainder and flags hold their last values until the next FIX.
  - done is a single pulse and never stays high for two consecutive cycles.
- start while busy=1 is ignored; operand inputs are don't-care while busy.
- start in the done cycle is accepted (state is IDLE), giving back-to-back operations with no idle gap.
- Exact result identity for all non-dz cases: dividend == quotient*divisor + remainder (mod 2^WIDTH), with |remainder| < |divisor|.

Test Plan:
- 100/7, start pulse at edge k -> done high after edge k+10 only; quotient=14 (8'h0E), remainder=2, flags 0; busy high for cycles k+1..k+9.
- Sign combinations, each with div_by_zero=0 and overflow=0:
  - -100/7 -> q=8'hF2 (-14), r=8'hFE (-2)
  - 100/-7 -> q=8'hF2, r=8'h02
  - -100/-7 -> q=8'h0E, r=8'hFE
- Most-negative dividend:
  - -128/-1 -> q=8'h80, r=0, overflow=1.
  - -128/1 -> q=8'h80, r=0, overflow=0.
  - -128/3 -> q=8'hD6 (-42), r=8'hFE (-2).
- 37/0 -> q=8'hFF, r=8'h25, div_by_zero=1, latency still 10.
- Handshake:
  - start re-pulsed at k+4 with other operands -> ignored, original result returned.
  - start asserted in the done cycle with 50/5 -> accepted; q=10, r=0 ten edges later.
- Async reset: rst_n low between edges k+4 and k+5 of an operation -> busy, done and outputs 0 immediately; no done after release; next 9/2 -> q=4, r=1.
